mem_sram_stage: RTL

Memory stage of the ARM pipeline, between the EXE/MEM pipeline register and MEM_Stage_Reg. It services LDR/STR by driving an external 16-bit SRAM: two half-word accesses per 32-bit word. While an access is in flight it stalls the pipeline with ready/freeze. Control and result fields pass through to MEM_Stage_Reg, and the assembled load word is presented on Mem_read_value.

---
 rtl/mem_sram_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_sram_stage.sv
// Memory stage of the ARM pipeline. Services LDR/STR through an external
// 16-bit SRAM using two half-word accesses per 32-bit word, stalls the
// pipeline while an access is in flight, and passes control fields through.
module mem_sram_stage #(
  parameter int ACC_CYCLES = 2,     // cycles each half-word access is held (>=1)
  parameter int ADDR_BASE  = 1024,  // byte address mapping to SRAM word 0
  parameter int SRAM_AW    = 18     // SRAM half-word address width
) (
  input  logic               clk,
  input  logic               rst,            // asynchronous, active-low
  input  logic               WB_en_in,
  input  logic               MEM_R_en_in,
  input  logic               MEM_W_en_in,
  input  logic [31:0]        ALU_result_in,
  input  logic [31:0]        Val_Rm_in,
  input  logic [3:0]         Dest_in,
  output logic               WB_en,
  output logic               MEM_R_en,
  output logic [31:0]        ALU_result,
  output logic [3:0]         Dest,
  output logic [31:0]        Mem_read_value,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int WA_W = SRAM_AW - 1;
  localparam int CW   = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     lo_q;
  logic [31:0]     rdata_q;

  logic            req;
  logic            is_load;
  logic            is_store;
  logic            phase_last;
  logic [WA_W-1:0] word_addr;

  // Control fields ride straight through to MEM_Stage_Reg.
  assign WB_en      = WB_en_in;
  assign MEM_R_en   = MEM_R_en_in;
  assign ALU_result = ALU_result_in;
  assign Dest       = Dest_in;

  // A simultaneous read and write request is serviced as a load, never a write.
  assign req      = MEM_R_en_in | MEM_W_en_in;
  assign is_load  = MEM_R_en_in;
  assign is_store = MEM_W_en_in & ~MEM_R_en_in;

  // Word index relative to the SRAM window; addresses below the base wrap silently.
  assign word_addr  = WA_W'((ALU_result_in - 32'(ADDR_BASE)) >> 2);
  assign phase_last = (cnt_q == CW'(ACC_CYCLES - 1));

  assign ready          = ((state_q == S_IDLE) & ~req) | (state_q == S_DONE);
  assign freeze         = ~ready;
  assign Mem_read_value = rdata_q;

  // State and phase-counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: each half-word phase lasts ACC_CYCLES cycles.
  // NOTE: every signal is defaulted before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LO;
          cnt_d   = '0;
        end
      end
      S_LO: begin
        if (phase_last) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: begin
        if (phase_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM bus drive: address and strobes only during the two access phases.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state_q == S_LO) begin
      sram_addr = {word_addr, 1'b0};
      if (is_store) begin
        sram_dq_out = Val_Rm_in[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
    end else if (state_q == S_HI) begin
      sram_addr = {word_addr, 1'b1};
      if (is_store) begin
        sram_dq_out = Val_Rm_in[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
    end
  end

  // Load capture: low half staged at the end of LO, whole word committed at
  // the end of HI so the visible value only changes when a load completes.
  // NOTE: these data registers are reset because the stage must present a
  // defined zero after reset; plain storage arrays would not need it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q    <= '0;
      rdata_q <= '0;
    end else if (is_load && phase_last) begin
      if (state_q == S_LO) begin
        lo_q <= sram_dq_in;
      end else if (state_q == S_HI) begin
        rdata_q <= {sram_dq_in, lo_q};
      end
    end
  end

endmodule
